// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_pkg
//  Description : Shared constants and types for the toggle-switch front end
//                and the downstream switch-priority / display stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package switch_pkg;

    localparam int SWITCH_COUNT             = 18;
    localparam int SAMPLE_DIVIDE_50MHZ_1KHZ = 50000;

    typedef logic [SWITCH_COUNT-1:0] switch_vec_t;

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bit
//  Description : Single-bit synchroniser plus stability filter. The raw input
//                passes through two flops. Its value is shifted into a
//                history register on each shared sample tick. The level flips
//                once the whole history agrees on the opposite value.
//  Ports       : Clock       - system clock (rising edge)
//                Resetn      - asynchronous active-low reset
//                i_tick      - shared sample-tick strobe
//                i_raw       - raw asynchronous switch input
//                o_level     - debounced level (registered)
//                o_level_nxt - value o_level takes on the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
    import switch_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level,
    output logic o_level_nxt
);

    logic                      r_sync1;
    logic                      r_sync2;
    logic [STABLE_SAMPLES-1:0] r_hist;
    logic                      r_level;

    // Acceptance looks at the registered history. The level therefore moves
    // one edge after the tick that completes a uniform run.
    always_comb begin
        o_level_nxt = r_level;
        if (&r_hist) begin
            o_level_nxt = 1'b1;
        end else if (~|r_hist) begin
            o_level_nxt = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (i_tick) begin
                r_hist <= {r_hist[STABLE_SAMPLES-2:0], r_sync2};
            end
            r_level <= o_level_nxt;
        end
    end

    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debouncer
//  Description : Synchronises and debounces the raw toggle-switch bus. Emits
//                clean levels plus a one-cycle change event carrying the
//                rise and fall masks.
//  Ports       : Clock    - 50 MHz system clock (rising edge)
//                Resetn   - asynchronous active-low reset
//                SWITCH_I - raw switch bus
//                SWITCH_O - debounced switch levels
//                CHANGE_O - one-cycle pulse when any SWITCH_O bit changes
//                RISE_O   - bits that went 0->1 (only while CHANGE_O=1)
//                FALL_O   - bits that went 1->0 (only while CHANGE_O=1)
//                TICK_O   - sample-tick strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int NUM_SWITCHES   = SWITCH_COUNT,
    parameter int SAMPLE_DIVIDE  = SAMPLE_DIVIDE_50MHZ_1KHZ,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic [NUM_SWITCHES-1:0] SWITCH_I,
    output logic [NUM_SWITCHES-1:0] SWITCH_O,
    output logic                    CHANGE_O,
    output logic [NUM_SWITCHES-1:0] RISE_O,
    output logic [NUM_SWITCHES-1:0] FALL_O,
    output logic                    TICK_O
);

    localparam int               CNT_W      = $clog2(SAMPLE_DIVIDE);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SAMPLE_DIVIDE - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic                    w_tick;
    logic [NUM_SWITCHES-1:0] w_level;
    logic [NUM_SWITCHES-1:0] w_level_nxt;
    logic                    r_change;
    logic [NUM_SWITCHES-1:0] r_rise;
    logic [NUM_SWITCHES-1:0] r_fall;

    // Shared prescaler: the tick is the terminal-count compare, and the
    // counter wraps on that same edge.
    assign w_tick = (r_cnt == C_CNT_LAST);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_bit
        debounce_bit #(
            .STABLE_SAMPLES (STABLE_SAMPLES)
        ) u_debounce_bit (
            .Clock       (Clock),
            .Resetn      (Resetn),
            .i_tick      (w_tick),
            .i_raw       (SWITCH_I[g]),
            .o_level     (w_level[g]),
            .o_level_nxt (w_level_nxt[g])
        );
    end

    // The event registers use the same next-level values that the level
    // flops load. The pulse and masks therefore line up with the new SWITCH_O
    // value, and they fall back to zero on any edge without an update.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_change <= 1'b0;
            r_rise   <= '0;
            r_fall   <= '0;
        end else begin
            r_change <= |(w_level_nxt ^ w_level);
            r_rise   <= w_level_nxt & ~w_level;
            r_fall   <= ~w_level_nxt & w_level;
        end
    end

    assign SWITCH_O = w_level;
    assign CHANGE_O = r_change;
    assign RISE_O   = r_rise;
    assign FALL_O   = r_fall;
    assign TICK_O   = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_debouncer
//  Description : Self-checking bench for switch_debouncer using a run-length
//                reference model and directed plus random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    localparam int N = 18;
    localparam int D = 4;
    localparam int S = 3;

    logic         Clock    = 1'b0;
    logic         Resetn   = 1'b0;
    logic [N-1:0] SWITCH_I = '0;
    logic [N-1:0] SWITCH_O;
    logic         CHANGE_O;
    logic [N-1:0] RISE_O;
    logic [N-1:0] FALL_O;
    logic         TICK_O;

    switch_debouncer #(
        .NUM_SWITCHES   (N),
        .SAMPLE_DIVIDE  (D),
        .STABLE_SAMPLES (S)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .SWITCH_I (SWITCH_I),
        .SWITCH_O (SWITCH_O),
        .CHANGE_O (CHANGE_O),
        .RISE_O   (RISE_O),
        .FALL_O   (FALL_O),
        .TICK_O   (TICK_O)
    );

    always #5 Clock = ~Clock;

    int checks     = 0;
    int failures   = 0;
    int change_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each bit is described by the value and length of its current run of
    // identical tick samples. A level is accepted once the run reaches S.
    logic [N-1:0] m_s1, m_s2, m_level, m_rise, m_fall, m_run_val;
    logic         m_change;
    int           m_run_len [N];
    int           m_n;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
        m_change = 1'b0; m_run_val = '0; m_n = 0;
        for (int b = 0; b < N; b++) m_run_len[b] = S;
    endtask

    function automatic logic m_tick();
        return (m_n % D) == (D - 1);
    endfunction

    task automatic model_step();
        logic [N-1:0] nl;
        nl = m_level;
        for (int b = 0; b < N; b++)
            if (m_run_len[b] >= S && m_run_val[b] != m_level[b]) nl[b] = m_run_val[b];
        m_change = (nl != m_level);
        m_rise   = nl & ~m_level;
        m_fall   = ~nl & m_level;
        if (m_tick()) begin
            for (int b = 0; b < N; b++) begin
                if (m_s2[b] == m_run_val[b]) begin
                    if (m_run_len[b] < 16) m_run_len[b]++;
                end else begin
                    m_run_val[b] = m_s2[b];
                    m_run_len[b] = 1;
                end
            end
        end
        m_s2    = m_s1;
        m_s1    = SWITCH_I;
        m_level = nl;
        m_n++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clock or negedge Resetn);
            if (!Resetn) model_reset();
            else         model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge Clock);
            chk("switch_o", SWITCH_O, m_level);
            chk("change_o", CHANGE_O, m_change);
            chk("rise_o",   RISE_O,   m_rise);
            chk("fall_o",   FALL_O,   m_fall);
            chk("tick_o",   TICK_O,   m_tick());
            if (CHANGE_O) change_cnt++;
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic cyc();
        @(negedge Clock);
        #2;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Wait up to max cycles for CHANGE_O. Returns the number of edges taken,
    // or -1 (recorded as a failure) when the bound expires.
    task automatic wait_change(input string name, input int max, output int edges);
        edges = -1;
        for (int i = 1; i <= max; i++) begin
            cyc();
            if (CHANGE_O) begin
                edges = i;
                break;
            end
        end
        if (edges < 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, e, ticks, idx;

        // Reset, then idle for 20 cycles.
        Resetn = 1'b0; SWITCH_I = '0;
        cycles(3);
        Resetn = 1'b1;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (TICK_O) ticks++;
        end
        chk("idle_ticks", ticks, 5);
        chk("idle_switch", SWITCH_O, 0);
        chk("idle_changes", change_cnt, 0);

        // Clean step on bit 17.
        c0 = change_cnt;
        SWITCH_I = 18'h20000;
        wait_change("step", 20, e);
        chk("step_latency_ok", (e - 1 >= 11 && e - 1 <= 14), 1);
        chk("step_switch", SWITCH_O, 18'h20000);
        chk("step_rise", RISE_O, 18'h20000);
        chk("step_fall", FALL_O, 0);
        cycles(10);
        chk("step_one_pulse", change_cnt - c0, 1);

        // Short glitch on bit 3.
        c0 = change_cnt;
        SWITCH_I[3] = 1'b1;
        cycles(5);
        SWITCH_I[3] = 1'b0;
        cycles(20);
        chk("glitch_switch", SWITCH_O, 18'h20000);
        chk("glitch_changes", change_cnt - c0, 0);

        // Simultaneous rise and fall.
        c0 = change_cnt;
        SWITCH_I = 18'h00401;
        wait_change("swap", 20, e);
        chk("swap_rise", RISE_O, 18'h00401);
        chk("swap_fall", FALL_O, 18'h20000);
        chk("swap_switch", SWITCH_O, 18'h00401);
        cycles(10);
        chk("swap_one_pulse", change_cnt - c0, 1);

        // Bounce on bit 0, then settle high.
        SWITCH_I = '0;
        cycles(20);
        chk("clear_switch", SWITCH_O, 0);
        c0 = change_cnt;
        for (int i = 0; i < 60; i++) begin
            SWITCH_I[0] = ((i / 3) % 2) == 0;
            cyc();
        end
        chk("bounce_changes", change_cnt - c0, 0);
        SWITCH_I[0] = 1'b1;
        wait_change("settle", 30, e);
        chk("settle_rise", RISE_O, 18'h00001);
        chk("settle_fall", FALL_O, 0);

        // Reset while bit 5's history is partly filled.
        SWITCH_I = 18'h00021;
        cycles(6);
        Resetn = 1'b0;
        #1;
        chk("rst_switch", SWITCH_O, 0);
        chk("rst_change", CHANGE_O, 0);
        chk("rst_rise", RISE_O, 0);
        chk("rst_fall", FALL_O, 0);
        chk("rst_tick", TICK_O, 0);
        cyc();
        Resetn = 1'b1;
        wait_change("post_rst", 20, e);
        chk("post_rst_edges", e, 13);
        chk("post_rst_rise", RISE_O, 18'h00021);

        // Random stimulus with occasional bursts, glitches and one reset.
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                Resetn = 1'b0;
                cyc();
                Resetn = 1'b1;
            end
            case ($urandom_range(19, 0))
                0:       SWITCH_I = N'($urandom);
                1, 2:    begin
                             idx = $urandom_range(N - 1, 0);
                             SWITCH_I[idx] = ~SWITCH_I[idx];
                         end
                default: ;
            endcase
            cyc();
        end
        chk("random_saw_events", change_cnt > 10, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_debouncer.md
# switch_debouncer

Front-end conditioning stage for the board's toggle switches. It synchronises the raw 18-bit switch bus into the clock domain and debounces each bit with a shared sample-rate prescaler and a per-bit stability filter. It publishes a clean switch vector plus a one-cycle change event with rise and fall masks. Its output replaces the raw switch bus at the input of the switch-priority / seven-segment display stage, so that stage never sees bounce or metastable values.

## Interface
Parameters:
- NUM_SWITCHES, 18: width of the switch bus.
- SAMPLE_DIVIDE, 50000: clock cycles per sample tick (1 kHz at 50 MHz). Legal range is at least 2.
- STABLE_SAMPLES, 4: number of consecutive identical samples required to accept a new level. Legal range is 2..16.

Ports:
- Clock  input  1: 50 MHz system clock; all state updates on the rising edge.
- Resetn  input  1: asynchronous, active-low reset.
- SWITCH_I  input  NUM_SWITCHES: raw, asynchronous toggle switches.
- SWITCH_O  output  NUM_SWITCHES: debounced switch levels.
- CHANGE_O  output  1: one-cycle pulse when any bit of SWITCH_O changes.
- RISE_O  output  NUM_SWITCHES: bits that went 0->1; valid only while CHANGE_O=1, all-zero otherwise.
- FALL_O  output  NUM_SWITCHES: bits that went 1->0; valid only while CHANGE_O=1, all-zero otherwise.
- TICK_O  output  1: sample-tick strobe, exported for display refresh and debug.

## Operation
- **Synchroniser:** two flops per bit, sync1 then sync2. Only sync2 feeds the filter.
- **Prescaler:** counter runs 0..SAMPLE_DIVIDE-1. Tick is asserted while counter == SAMPLE_DIVIDE-1; the counter wraps to 0 on the same edge. TICK_O is that combinational compare, and it is high for exactly 1 cycle per period.
- **Per-bit filter:** history shift register of STABLE_SAMPLES bits. On each tick edge, it shifts in sync2 (LSB newest). It holds between ticks.
- **Acceptance:**
  - On any edge where history is all-ones and SWITCH_O bit = 0, set the bit.
  - On any edge where history is all-zeros and SWITCH_O bit = 1, clear the bit.
  - Mixed history means the bit holds.
- **Event:** on the edge where one or more bits update, register the following:
  - CHANGE_O = 1.
  - RISE_O = new & ~old.
  - FALL_O = ~new & old.
  - Next cycle, all three return to 0 unless another update occurs on that edge.
- Several bits updating on the same edge produce a single CHANGE_O pulse, with every affected bit set in the masks.
- A rise on one bit and a fall on another in the same cycle report both masks together.
- A glitch shorter than STABLE_SAMPLES consecutive ticks never changes SWITCH_O.
- **Reset:** asserting Resetn low at any time, including mid-filter, immediately clears all of the following:
  - sync flops, history, prescaler.
  - SWITCH_O = 0, CHANGE_O = 0, RISE_O = 0, FALL_O = 0.
  - TICK_O is 0 because the counter is 0.
- **After reset release:** switches already high at release are accepted as a normal 0->1 change and produce a CHANGE_O pulse with RISE_O set.

## Timing
- Sync latency is 2 edges.
- The filter samples only on tick edges. Acceptance is evaluated on the registered history, so SWITCH_O updates 1 edge after the tick that completes the run.
- **Latency** from a clean raw step (set up before edge k) to SWITCH_O/CHANGE_O high is (STABLE_SAMPLES-1)*SAMPLE_DIVIDE + 3 edges minimum and STABLE_SAMPLES*SAMPLE_DIVIDE + 2 edges maximum, depending on prescaler phase.
- No handshake: the consumer must sample CHANGE_O/RISE_O/FALL_O in the same cycle. There is no back-pressure or queuing.
- Minimum spacing between CHANGE_O pulses on one bit is STABLE_SAMPLES ticks. Different bits may change on consecutive cycles only through tick alignment; in practice at most one event per tick + 1.

## Structure
- **Shared package** switch_pkg holds:
  - localparam SWITCH_COUNT = 18.
  - SAMPLE_DIVIDE_50MHZ_1KHZ = 50000.
  - typedef logic [SWITCH_COUNT-1:0] switch_vec_t, reused by the priority/display stage.
- **One sub-module** debounce_bit holds the sync flops, history register, and level flop for a single bit. It takes Clock, Resetn, tick, raw in and produces level out. It is instantiated NUM_SWITCHES times via generate.
- The prescaler and event/mask registers live in the top module.

## Test plan
Bench parameters: SAMPLE_DIVIDE=4, STABLE_SAMPLES=3.
- Reset with SWITCH_I=18'h00000, hold 20 cycles -> SWITCH_O=0; CHANGE_O never asserts; TICK_O pulses every 4 cycles.
- Step SWITCH_I to 18'h20000 -> SWITCH_O=18'h20000 within 11..14 edges; exactly one CHANGE_O cycle with RISE_O=18'h20000, FALL_O=0.
- From 18'h20000, pulse bit 3 high for 5 cycles (fewer than 3 consecutive ticks) -> SWITCH_O stays 18'h20000; no CHANGE_O.
- Step 18'h20000->18'h00401 on one edge -> single CHANGE_O with RISE_O=18'h00401 and FALL_O=18'h20000; SWITCH_O=18'h00401.
- Toggle bit 0 every 3 cycles for 60 cycles (bounce) then hold 1 -> no CHANGE_O during toggling; one RISE_O=18'h00001 after settling.
- Assert Resetn low for 1 cycle while bit 5's history is partially filled -> all outputs 0 immediately; bit 5 is then accepted only after a full fresh stability window.
